// File: rtl/regfile_wb_arbiter.sv
// Two-port (ALU / load) round-robin writeback arbiter for a 16-entry register file.
// An optional pending-write scoreboard is built when the WB_SCOREBOARD_EN macro is defined.
module regfile_wb_arbiter #(
    parameter int unsigned NREG = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [3:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        wb_en,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        iss_valid,
    input  logic [3:0]  iss_rd,
    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t lg;
    grant_t lg_next;
    logic   xfer;

    // The requester not last granted wins contention; a lone requester always wins.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            a_ready = a_valid && (!b_valid || (lg == GRANT_B));
            b_ready = b_valid && (!a_valid || (lg == GRANT_A));
        end
    end

    assign xfer = a_ready || b_ready;

    always_comb begin
        lg_next = lg;
        if (a_ready) begin
            lg_next = GRANT_A;
        end else if (b_ready) begin
            lg_next = GRANT_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lg      <= GRANT_B;
            wb_en   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            lg    <= lg_next;
            wb_en <= xfer;
            if (a_ready) begin
                wb_rd   <= a_rd;
                wb_data <= a_data;
            end else if (b_ready) begin
                wb_rd   <= b_rd;
                wb_data <= b_data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NREG-1:0] pending;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid) begin
            set_mask[iss_rd] = 1'b1;
        end
        if (wb_en) begin
            clr_mask[wb_rd] = 1'b1;
        end
    end

    // Set applied after clear so a same-edge reissue keeps the register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign rs1_busy = !rst && pending[rs1];
    assign rs2_busy = !rst && pending[rs2];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{iss_valid, iss_rd, rs1, rs2};
    assign rs1_busy = 1'b0;
    assign rs2_busy = 1'b0;
`endif

endmodule
